goose_game_ctrl: RTL and testbench

GOOSE_GAME_CTRL -- requirements
Module: goose_game_ctrl

---
 rtl/goose_pkg.sv | 24 ++
 rtl/bcd4_inc.sv | 34 +++
 rtl/goose_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_goose_game_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/goose_pkg.sv
// rtl/goose_pkg.sv - shared state encoding, colours and screen limits for the goose game
// Purpose: common definitions imported by goose_game_ctrl and bcd4_inc.
// Ports: none (package).
package goose_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] LAST_X   = SCREEN_W - 10'd1;
  localparam logic [9:0] LAST_Y   = SCREEN_H - 10'd1;

  localparam logic [11:0] GOOSE_RGB_DEF = 12'hF99;
  localparam logic [11:0] OBST_RGB_DEF  = 12'h0A0;
  localparam logic [11:0] BG_RGB_DEF    = 12'hFFF;
  localparam logic [11:0] OVER_RGB_DEF  = 12'hF00;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd4_inc.sv
// rtl/bcd4_inc.sv - four-digit BCD increment with saturation at 9999
// Purpose: combinational +1 on a packed 4-digit BCD value.
// Ports: cur  in  16  current BCD value, cur[15:12] most significant
//        inc  out 16  cur + 1 in BCD, or cur unchanged when cur is 9999
module bcd4_inc
  import goose_pkg::*;
(
  input  logic [15:0] cur,
  output logic [15:0] inc
);

  logic       carry;
  logic [3:0] digit;

  always_comb begin
    inc   = cur;
    carry = 1'b1;
    digit = 4'd0;
    if (cur != SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        digit = cur[4*i +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            inc[4*i +: 4] = 4'd0;
          end else begin
            inc[4*i +: 4] = digit + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/goose_game_ctrl.sv
// rtl/goose_game_ctrl.sv - goose game state, lives, score and pixel colour controller
// Purpose: IDLE/RUN/OVER game FSM driven by frame ticks, collision latch,
//          BCD score with frame divider, post-hit grace period and pixel colouring.
// Ports: clk       in   1   system clock
//        reset     in   1   synchronous active-high reset
//        x, y      in  10   current pixel column / row
//        goose     in   1   goose pixel flag for (x,y)
//        obstacle  in   1   obstacle pixel flag for (x,y)
//        btnC      in   1   debounced start/restart button level
//        run       out  1   game running
//        game_over out  1   game over
//        lives     out  3   remaining lives
//        score     out 16   BCD score
//        rgb       out 12   registered pixel colour
module goose_game_ctrl
  import goose_pkg::*;
#(
  parameter int          FRAME_DIV    = 6,
  parameter int          LIVES        = 3,
  parameter int          GRACE_FRAMES = 60,
  parameter logic [11:0] GOOSE_RGB    = GOOSE_RGB_DEF,
  parameter logic [11:0] OBST_RGB     = OBST_RGB_DEF,
  parameter logic [11:0] BG_RGB       = BG_RGB_DEF,
  parameter logic [11:0] OVER_RGB     = OVER_RGB_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        goose,
  input  logic        obstacle,
  input  logic        btnC,
  output logic        run,
  output logic        game_over,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [11:0] rgb
);

  localparam int DW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);
  localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_FRAMES);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  state_t         state_q, state_d;
  logic [2:0]     lives_q, lives_d;
  logic [15:0]    score_q, score_d, score_inc;
  logic [GW-1:0]  grace_q, grace_d;
  logic [DW-1:0]  div_q, div_d;
  logic           hit_q, at_end_q, btn_low_q, frame_odd_q;
  logic [11:0]    rgb_q, rgb_d;

  logic at_end, frame_tick, overlap, hit_take, btn_rise, fatal, on_screen;

  assign at_end     = (x == LAST_X) && (y == LAST_Y);
  assign frame_tick = at_end && !at_end_q;
  assign overlap    = goose && obstacle;
  // Overlap on the tick cycle itself still belongs to the frame being closed.
  assign hit_take   = hit_q || overlap;
  // The register holds "button was low last cycle"; clearing it in reset means a
  // button held through reset cannot look like a fresh press.
  assign btn_rise   = btnC && btn_low_q;
  assign fatal      = hit_take && (grace_q == '0) && (lives_q == 3'd1);
  assign on_screen  = (x < SCREEN_W) && (y < SCREEN_H);

  bcd4_inc u_bcd4_inc (
    .cur (score_q),
    .inc (score_inc)
  );

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    grace_d = grace_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d = ST_RUN;
          lives_d = LIVES_INIT;
          score_d = '0;
          grace_d = '0;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          if (hit_take && (grace_q == '0)) begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) state_d = ST_OVER;
            else                 grace_d = GRACE_LOAD;
          end else if (grace_q != '0) begin
            grace_d = grace_q - GW'(1);
          end
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!fatal) score_d = score_inc;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
      end
      ST_OVER: begin
        if (btn_rise) begin
          state_d = ST_IDLE;
          score_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rgb_d = BG_RGB;
    if (!on_screen)                          rgb_d = 12'h000;
    else if (goose)                          rgb_d = ((grace_q != '0) && frame_odd_q) ? BG_RGB : GOOSE_RGB;
    else if (obstacle)                       rgb_d = OBST_RGB;
    else if (state_q == ST_OVER)             rgb_d = OVER_RGB;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      grace_q     <= '0;
      div_q       <= '0;
      hit_q       <= 1'b0;
      at_end_q    <= 1'b0;
      btn_low_q   <= 1'b0;
      frame_odd_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      grace_q     <= grace_d;
      div_q       <= div_d;
      hit_q       <= frame_tick ? 1'b0 : hit_take;
      at_end_q    <= at_end;
      btn_low_q   <= !btnC;
      frame_odd_q <= frame_odd_q ^ frame_tick;
      rgb_q       <= rgb_d;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign game_over = (state_q == ST_OVER);
  assign lives     = lives_q;
  assign score     = score_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_goose_game_ctrl.sv
// tb/tb_goose_game_ctrl.sv - randomized self-checking bench for goose_game_ctrl
module tb_goose_game_ctrl;

  localparam int FD = 3;
  localparam int NL = 3;
  localparam int GF = 60;
  localparam logic [11:0] C_GOOSE = 12'hF99;
  localparam logic [11:0] C_OBST  = 12'h0A0;
  localparam logic [11:0] C_BG    = 12'hFFF;
  localparam logic [11:0] C_OVER  = 12'hF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = 10'd0, y = 10'd0;
  logic        goose = 1'b0, obstacle = 1'b0, btnC = 1'b0;
  logic        run, game_over;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [11:0] rgb;

  goose_game_ctrl #(.FRAME_DIV(FD), .LIVES(NL), .GRACE_FRAMES(GF)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .goose(goose), .obstacle(obstacle),
    .btnC(btnC), .run(run), .game_over(game_over), .lives(lives), .score(score), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 over; score kept as a decimal integer.
  int   m_mode, m_lives, m_score, m_grace, m_div;
  bit   m_odd, m_hit, m_prev_end, m_btn_prev;
  logic [11:0] m_rgb;
  bit   l_r, l_g, l_o, l_b;
  int   l_x, l_y;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = NL; m_score = 0; m_grace = 0; m_div = 0;
    m_odd = 0; m_hit = 0; m_prev_end = 0; m_btn_prev = 1; m_rgb = 12'h000;
  endtask

  task automatic model_step(input bit r, input int xx, input int yy, input bit g, input bit o, input bit b);
    bit ovl, is_end, tick, rise, hit_any, fatal_hit;
    if (r) begin
      model_reset();
      return;
    end
    ovl = g && o;
    is_end = (xx == 639) && (yy == 479);
    tick = is_end && !m_prev_end;
    m_prev_end = is_end;
    rise = b && !m_btn_prev;
    m_btn_prev = b;
    if (xx >= 640 || yy >= 480) m_rgb = 12'h000;
    else if (g)                 m_rgb = (m_grace != 0 && m_odd) ? C_BG : C_GOOSE;
    else if (o)                 m_rgb = C_OBST;
    else if (m_mode == 2)       m_rgb = C_OVER;
    else                        m_rgb = C_BG;
    hit_any = m_hit || ovl;
    fatal_hit = 0;
    if (m_mode == 0) begin
      if (rise) begin
        m_mode = 1; m_lives = NL; m_score = 0; m_grace = 0;
      end
    end else if (m_mode == 1) begin
      if (tick) begin
        if (hit_any && m_grace == 0) begin
          if (m_lives == 1) begin
            fatal_hit = 1;
            m_mode = 2;
          end else begin
            m_grace = GF;
          end
          m_lives = m_lives - 1;
        end else if (m_grace > 0) begin
          m_grace = m_grace - 1;
        end
        m_div = m_div + 1;
        if (m_div == FD) begin
          m_div = 0;
          if (!fatal_hit && m_score < 9999) m_score = m_score + 1;
        end
      end
    end else begin
      if (rise) begin
        m_mode = 0; m_score = 0;
      end
    end
    m_hit = tick ? 1'b0 : hit_any;
    if (tick) m_odd = !m_odd;
  endtask

  task automatic check_outputs();
    check_eq("run", run, m_mode == 1);
    check_eq("game_over", game_over, m_mode == 2);
    check_eq("lives", lives, m_lives);
    check_eq("score", score, to_bcd(m_score));
    check_eq("rgb", rgb, m_rgb);
  endtask

  task automatic step(input bit r, input int xx, input int yy, input bit g, input bit o, input bit b);
    @(negedge clk);
    check_outputs();
    reset = r; x = 10'(xx); y = 10'(yy); goose = g; obstacle = o; btnC = b;
    l_r = r; l_x = xx; l_y = yy; l_g = g; l_o = o; l_b = b;
    model_step(r, xx, yy, g, o, b);
  endtask

  // One extra cycle with inputs held, plus directed checks against fixed values.
  task automatic expect_state(input string tag, input bit erun, input bit eover, input int elives, input int escore);
    @(negedge clk);
    check_outputs();
    check_eq({tag, "_run"}, run, erun);
    check_eq({tag, "_over"}, game_over, eover);
    check_eq({tag, "_lives"}, lives, elives);
    check_eq({tag, "_score"}, score, to_bcd(escore));
    model_step(l_r, l_x, l_y, l_g, l_o, l_b);
  endtask

  task automatic frame(input int npre, input bit ovl_body, input bit ovl_tick, input bit b_body);
    int xx, yy;
    bit g, o;
    for (int i = 0; i < npre; i++) begin
      xx = $urandom_range(0, 1023);
      yy = $urandom_range(0, 1023);
      if (xx == 639 && yy == 479) yy = 0;
      g = 1'($urandom_range(0, 1));
      o = g ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 0 && ovl_body) begin
        xx = 120; yy = 350; g = 1; o = 1;
      end
      step(0, xx, yy, g, o, (i == 0) ? b_body : 1'b0);
    end
    step(0, 639, 479, ovl_tick, ovl_tick, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  int saved;

  initial begin
    model_reset();
    // Power-on reset and start
    do_reset();
    expect_state("reset", 0, 0, NL, 0);
    frame(2, 0, 0, 1);
    for (int i = 0; i < 6; i++) frame(2, 0, 0, 0);
    expect_state("six_frames", 1, 0, NL, 6 / FD + 1 / FD);

    // First hit, then grace window with continuous overlap
    frame(2, 1, 0, 0);
    expect_state("first_hit", 1, 0, NL - 1, m_score);
    for (int i = 0; i < GF; i++) frame(1, 1, 0, 0);
    expect_state("grace_hold", 1, 0, NL - 1, m_score);
    frame(1, 1, 0, 0);
    expect_state("second_hit", 1, 0, NL - 2, m_score);
    for (int i = 0; i < GF; i++) frame(1, 0, 0, 0);
    while (m_div != FD - 1) frame(1, 0, 0, 0);
    saved = m_score;
    // Fatal overlap on the tick cycle only, divider wrapping on the same tick
    frame(2, 0, 1, 0);
    expect_state("fatal_tick", 0, 1, 0, saved);
    for (int i = 0; i < 4; i++) frame(2, 0, 0, 0);
    expect_state("over_frozen", 0, 1, 0, saved);
    frame(2, 0, 0, 1);
    expect_state("back_idle", 0, 0, 0, 0);

    // Reset mid-run with the button held
    frame(2, 0, 0, 1);
    for (int i = 0; i < 4; i++) frame(2, 0, 0, 0);
    step(1, 5, 5, 0, 0, 1);
    step(1, 5, 5, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 7, 7, 0, 0, 1);
    expect_state("held_reset", 0, 0, NL, 0);
    step(0, 7, 7, 0, 0, 0);
    step(0, 7, 7, 0, 0, 1);
    expect_state("repress", 1, 0, NL, 0);

    // Random play including restarts
    for (int i = 0; i < 400; i++)
      frame($urandom_range(1, 5), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0);

    // Score carry and saturation
    do_reset();
    frame(2, 0, 0, 1);
    while (m_score < 99) frame(1, 0, 0, 0);
    expect_state("score_99", 1, 0, NL, 99);
    for (int i = 0; i < FD; i++) frame(1, 0, 0, 0);
    expect_state("score_100", 1, 0, NL, 100);
    while (m_score < 9999) frame(1, 0, 0, 0);
    for (int i = 0; i < 2 * FD; i++) frame(1, 0, 0, 0);
    expect_state("score_sat", 1, 0, NL, 9999);

    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
